// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: register-mapped four-digit seven-segment scanner with hex font decode.
module seg_display_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  regSel,
  input  logic        writeEnable,
  input  logic        readEnable,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [15:0]   data;
  logic          en;
  logic [3:0]    mask;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic [6:0]    font;
  logic [31:0]   rd_mux;
  logic          tc;
  logic          show;
  logic          unused_wd;
  assign unused_wd = ^writeData[31:16];
  assign tc = cnt == CW'(REFRESH_DIV - 1);
  assign nib = data[idx*4 +: 4];
  assign show = en & mask[idx];
  assign rd_mux = regSel == 2'd0 ? {16'b0, data} :
                  regSel == 2'd1 ? {24'b0, mask, 3'b0, en} :
                  regSel == 2'd2 ? {29'b0, en, idx} : 32'b0;
  always_comb begin
    font = 7'h7F;
    case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
      default: font = 7'h7F;
    endcase
  end
  // seg/an are registered from pre-edge state, so a digit change lags the counter wrap by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data     <= '0;
      en       <= 1'b1;
      mask     <= 4'hF;
      cnt      <= '0;
      idx      <= '0;
      readData <= '0;
      seg      <= 7'h7F;
      an       <= 4'hF;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc) idx <= idx + 2'd1;
      if (writeEnable && regSel == 2'd0) data <= writeData[15:0];
      if (writeEnable && regSel == 2'd1) begin
        en   <= writeData[0];
        mask <= writeData[7:4];
      end
      readData <= readEnable ? rd_mux : 32'b0;
      an       <= show ? ~(4'b1 << idx) : 4'hF;
      seg      <= show ? font : 7'h7F;
    end
  end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed checks of reset, scan, masking, register access and async reset.
module tb_seg_display_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        we;
  logic        re;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [6:0]  seg;
  logic [3:0]  an;
  int          k;
  int          d;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  scan_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0]  scan_seg [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};

  seg_display_ctrl #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .regSel(sel), .writeEnable(we), .readEnable(re),
    .writeData(wd), .readData(rd), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; sel = 2'd0; wd = 32'b0; k = 0;
    repeat (3) tick();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_rd", rd, 32'h0);
    rst = 1'b0; k = 0;
    tick();
    check("first_an", 32'(an), 32'hE);
    check("first_seg", 32'(seg), 32'h40);
    re = 1'b1; sel = 2'd1;
    tick();
    check("ctrl_reset_rd", rd, 32'hF1);
    re = 1'b0; we = 1'b1; sel = 2'd0; wd = 32'h1A3F;
    tick();
    we = 1'b0;
    while (k < 20) begin
      tick();
      d = ((k - 1) >> 2) & 3;
      check($sformatf("scan_an_k%0d", k), 32'(an), 32'(scan_an[d]));
      check($sformatf("scan_seg_k%0d", k), 32'(seg), 32'(scan_seg[d]));
    end
    we = 1'b1; sel = 2'd1; wd = 32'h51;
    tick();
    we = 1'b0;
    while (k < 37) begin
      tick();
      d = ((k - 1) >> 2) & 3;
      check($sformatf("mask_an_k%0d", k), 32'(an), d[0] ? 32'hF : 32'(scan_an[d]));
      check($sformatf("mask_seg_k%0d", k), 32'(seg), d[0] ? 32'h7F : 32'(scan_seg[d]));
    end
    we = 1'b1; wd = 32'h50;
    tick();
    we = 1'b0; re = 1'b1; sel = 2'd2;
    while (k < 54) begin
      tick();
      check($sformatf("dis_an_k%0d", k), 32'(an), 32'hF);
      check($sformatf("dis_seg_k%0d", k), 32'(seg), 32'h7F);
      check($sformatf("dis_status_k%0d", k), rd, 32'(((k - 1) >> 2) & 3));
    end
    re = 1'b0; we = 1'b1; sel = 2'd1; wd = 32'hF1;
    tick();
    sel = 2'd0; wd = 32'h1234;
    tick();
    wd = 32'hBEEF; re = 1'b1;
    tick();
    check("collide_old", rd, 32'h1234);
    we = 1'b0;
    tick();
    check("readback_new", rd, 32'h0000BEEF);
    sel = 2'd3;
    tick();
    check("reserved_rd", rd, 32'h0);
    we = 1'b1; sel = 2'd2; wd = 32'hFFFF_FFFF; re = 1'b0;
    tick();
    check("idle_rd", rd, 32'h0);
    we = 1'b0; re = 1'b1;
    tick();
    check("status_after_wr", rd, 32'h7);
    re = 1'b0;
    tick();
    check("rd_one_cycle", rd, 32'h0);
    while (k < 72) tick();
    re = 1'b1; sel = 2'd2;
    tick();
    check("status_idx2", rd, 32'h6);
    re = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_rd", rd, 32'h0);
    #1 rst = 1'b0; k = 0;
    tick();
    check("restart_an", 32'(an), 32'hE);
    check("restart_seg", 32'(seg), 32'h40);
    re = 1'b1; sel = 2'd0;
    tick();
    check("data_cleared", rd, 32'h0);
    re = 1'b0;
    tick();
    tick();
    check("restart_d0_hold", 32'(an), 32'hE);
    tick();
    check("restart_d1_an", 32'(an), 32'hD);
    check("restart_d1_seg", 32'(seg), 32'h40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
